// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants, requester IDs and helpers for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    function automatic logic [NREG-1:0] rd_onehot(input logic [AW-1:0] rd);
        logic [NREG-1:0] vec;
        vec     = {NREG{1'b0}};
        vec[rd] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is actually taken.
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output req_id_e    grant_id,
    output logic       xfer
);

    req_id_e last_grant_r;

    // Grant decision: a lone requester wins, contention goes to the one not served last
    always_comb begin
        grant    = 2'b00;
        grant_id = REQ_ALU;
        if (rst) begin
            grant    = 2'b00;
            grant_id = REQ_ALU;
        end else begin
            case (req)
                2'b01: begin
                    grant    = 2'b01;
                    grant_id = REQ_ALU;
                end
                2'b10: begin
                    grant    = 2'b10;
                    grant_id = REQ_MEM;
                end
                2'b11: begin
                    if (last_grant_r == REQ_ALU) begin
                        grant    = 2'b10;
                        grant_id = REQ_MEM;
                    end else begin
                        grant    = 2'b01;
                        grant_id = REQ_ALU;
                    end
                end
                default: begin
                    grant    = 2'b00;
                    grant_id = REQ_ALU;
                end
            endcase
        end
    end

    assign xfer = grant[0] | grant[1];

    // Round-robin pointer, reset so the ALU wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= REQ_MEM;
        end else if (xfer) begin
            last_grant_r <= grant_id;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/load writebacks onto the register-file write port and tracks pending writes.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_rd_busy,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wb_we,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [NREG-1:0] pending
);

    localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

    logic [1:0]      grant_s;
    req_id_e         grant_id_s;
    logic            xfer_s;
    logic [AW-1:0]   win_rd_s;
    logic [XLEN-1:0] win_data_s;
    logic [NREG-1:0] set_s;
    logic [NREG-1:0] clr_s;
    logic            wb_we_r;
    logic [AW-1:0]   wb_rd_r;
    logic [XLEN-1:0] wb_data_r;
    logic [NREG-1:0] pending_r;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({req1_valid, req0_valid}),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .xfer     (xfer_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Winner mux feeding the write-port registers and the scoreboard clear
    always_comb begin
        win_rd_s   = req0_rd;
        win_data_s = req0_data;
        if (grant_id_s == REQ_MEM) begin
            win_rd_s   = req1_rd;
            win_data_s = req1_data;
        end else begin
            win_rd_s   = req0_rd;
            win_data_s = req0_data;
        end
    end

    // Scoreboard set/clear vectors; x0 is never marked pending
    always_comb begin
        set_s = {NREG{1'b0}};
        clr_s = {NREG{1'b0}};
        if (iss_valid && (iss_rd != {AW{1'b0}})) begin
            set_s = rd_onehot(iss_rd);
        end else begin
            set_s = {NREG{1'b0}};
        end
        if (xfer_s) begin
            clr_s = rd_onehot(win_rd_s);
        end else begin
            clr_s = {NREG{1'b0}};
        end
    end

    // Write-port registers and pending bitmap; a same-edge set beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_r   <= 1'b0;
            wb_rd_r   <= {AW{1'b0}};
            wb_data_r <= {XLEN{1'b0}};
            pending_r <= {NREG{1'b0}};
        end else begin
            if (xfer_s) begin
                wb_we_r   <= (win_rd_s != {AW{1'b0}});
                wb_rd_r   <= win_rd_s;
                wb_data_r <= win_data_s;
            end else begin
                wb_we_r   <= 1'b0;
                wb_rd_r   <= wb_rd_r;
                wb_data_r <= wb_data_r;
            end
            pending_r <= ((pending_r & ~clr_s) | set_s) & X0_MASK;
        end
    end

    assign wb_we       = wb_we_r;
    assign wb_rd       = wb_rd_r;
    assign wb_data     = wb_data_r;
    assign pending     = pending_r;
    assign rs1_busy    = pending_r[rs1];
    assign rs2_busy    = pending_r[rs2];
    assign iss_rd_busy = pending_r[iss_rd];

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 register file (rd / data_in / reg_write) between two writeback requesters: ALU (req0) and load/memory (req1).
- Maintains a pending-write scoreboard so the issue stage can stall on RAW/WAW hazards.
- Sits between the execute/memory writeback paths and the register file.
- Drives the register file's write inputs directly from registered outputs.

Parameters:
XLEN, 32, data width of register file entries
NREG, 32, number of architectural registers
AW, 5, register index width (log2 NREG)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  ALU writeback request
req0_rd  in  AW  ALU destination register
req0_data  in  XLEN  ALU result
req0_ready  out  1  ALU request accepted this cycle
req1_valid  in  1  load writeback request
req1_rd  in  AW  load destination register
req1_data  in  XLEN  load data
req1_ready  out  1  load request accepted this cycle
iss_valid  in  1  instruction issued that will write iss_rd
iss_rd  in  AW  destination of issued instruction
iss_rd_busy  out  1  iss_rd has a pending write (WAW stall)
rs1  in  AW  source register 1 of instruction in decode
rs2  in  AW  source register 2 of instruction in decode
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
wb_we  out  1  to register file reg_write
wb_rd  out  AW  to register file rd
wb_data  out  XLEN  to register file data_in
pending  out  NREG  scoreboard bitmap, bit i = register i pending

Behaviour:
- Reset values: wb_we=0, wb_rd=0, wb_data=0, pending=0. Round-robin pointer last_grant=1, so req0 wins the first contention.
- Handshake:
  - reqN_ready is combinational and equals grantN.
  - A transfer occurs when valid && ready in the same cycle.
  - A requester holds valid, rd and data stable until it is accepted.
  - Ready never depends on itself; at most one grant per cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates only on a transfer.
  - No valid requester: no grant, last_grant holds.
- Write port, latency 1:
  - On the transfer edge, register wb_rd and wb_data from the winner.
  - wb_we=1 when the winner's rd!=0. When rd==0 the request is still accepted but wb_we=0 (x0 write suppressed).
  - With no transfer, wb_we=0 next cycle; wb_rd and wb_data hold.
- Scoreboard:
  - On each edge, pending_next = (pending & ~clr) | set.
  - set = one-hot(iss_rd) when iss_valid && iss_rd!=0.
  - clr = one-hot(winner rd) on a transfer.
  - Same rd set and cleared on one edge: set wins (newer producer).
  - pending[0] is constant 0.
- Busy outputs:
  - rs1_busy = pending[rs1], rs2_busy = pending[rs2], iss_rd_busy = pending[iss_rd]. All combinational from registered state.
  - Registers 0 always read not-busy.
- Ordering contract:
  - At most one outstanding writer per register. Upstream must stall issue while iss_rd_busy.
  - Issuing to an already-pending rd leaves the bit set; no counting.
  - A writeback to a non-pending rd is legal: the write occurs and the clear has no effect.
- Read coherence: the register file writes combinationally while reg_write is high. A register therefore reads its new value in the cycle wb_we is asserted, which is the first cycle its busy bit is 0. No additional bypass is required.
- Reset mid-operation:
  - An accepted write latched in the wb_* registers is dropped (wb_we=0 the cycle after rst).
  - All pending bits are cleared and the arbitration pointer returns to its reset value.
  - Requests presented while rst=1 are not granted (ready=0).

Decomposition:
- Shared package: XLEN, AW, NREG constants; requester ID encoding (REQ_ALU=0, REQ_MEM=1).
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with pointer register and update-on-transfer input.
- Scoreboard and write-port registers stay in the top block.

Test Plan:
- Reset then single req0 (rd=5, data=0x1234_5678): req0_ready=1 same cycle; next cycle wb_we=1, wb_rd=5, wb_data=0x12345678.
- Both valid continuously (req0 rd=3, req1 rd=4) for 4 cycles: grants alternate req0, req1, req0, req1; wb_rd sequence 3, 4, 3, 4.
- iss_valid with iss_rd=7, then rs1=7: rs1_busy=1 and pending=0x80. After req1 writes rd=7: rs1_busy=0 in the wb_we cycle.
- req0 with rd=0, data=0xFFFFFFFF: req0_ready=1, wb_we=0 next cycle, pending[0]=0; iss_valid with iss_rd=0 leaves pending=0.
- Same edge: iss_rd=9 issued while req0 writes back rd=9 (pending[9]=1) -> pending[9] remains 1 and iss_rd_busy=1 the following cycle.
- Transfer accepted, rst asserted the next cycle -> wb_we=0 the cycle after rst, pending=0, req0 wins the first contention after reset release.
